// File: rtl/conv2d_im2col.sv
// conv2d_im2col: buffers one raster frame and regenerates it as packed KxK stride-1 patches for the conv2d block.
// Optional CONV2D_IM2COL_ZERO_PAD_EN adds one-pixel zero padding on every border (KERNEL_SIZE must be 3).
module conv2d_im2col #(
   parameter int unsigned BITWIDTH    = 8,
   parameter int unsigned IN_WIDTH    = 4,
   parameter int unsigned IN_HEIGHT   = 4,
   parameter int unsigned KERNEL_SIZE = 3,
`ifdef CONV2D_IM2COL_ZERO_PAD_EN
   localparam int unsigned OUT_W = IN_WIDTH,
   localparam int unsigned OUT_H = IN_HEIGHT,
`else
   localparam int unsigned OUT_W = IN_WIDTH - KERNEL_SIZE + 1,
   localparam int unsigned OUT_H = IN_HEIGHT - KERNEL_SIZE + 1,
`endif
   localparam int unsigned FEATURE_MAP_NUM = OUT_W * OUT_H,
   localparam int unsigned PATCH           = KERNEL_SIZE * KERNEL_SIZE,
   localparam int unsigned FM_W            = FEATURE_MAP_NUM * PATCH * BITWIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BITWIDTH-1:0] pixel_in,
   input  logic                pixel_valid,
   output logic                pixel_ready,
   output logic [FM_W-1:0]     feature_maps,
   output logic                calculate_start,
   input  logic                calculate_done,
   output logic                busy
);

   localparam int unsigned NPIX  = IN_WIDTH * IN_HEIGHT;
   localparam int unsigned CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int unsigned FR_W  = NPIX * BITWIDTH;

   typedef enum logic [1:0] {LOAD, BUILD, START, WAIT} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [FR_W-1:0]    frame_q, frame_d;
   logic [FM_W-1:0]    fm_q, fm_d;
   logic               ready_q, ready_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic               accept;

   // Rearranges a raster frame into MSB-first patches, element (i,j) of window (r,c) per slot.
   function automatic logic [FM_W-1:0] im2col(input logic [FR_W-1:0] frame);
      logic [FM_W-1:0] fm;
      int              row;
      int              col;
      int              p;
      int              e;
      fm = '0;
      for (int r = 0; r < int'(OUT_H); r++) begin
         for (int c = 0; c < int'(OUT_W); c++) begin
            for (int i = 0; i < int'(KERNEL_SIZE); i++) begin
               for (int j = 0; j < int'(KERNEL_SIZE); j++) begin
                  p = r * int'(OUT_W) + c;
                  e = i * int'(KERNEL_SIZE) + j;
`ifdef CONV2D_IM2COL_ZERO_PAD_EN
                  row = r + i - 1;
                  col = c + j - 1;
                  if (row >= 0 && row < int'(IN_HEIGHT) && col >= 0 && col < int'(IN_WIDTH)) begin
                     fm[((int'(FEATURE_MAP_NUM) - 1 - p) * int'(PATCH) + (int'(PATCH) - 1 - e))
                        * int'(BITWIDTH) +: BITWIDTH] =
                        frame[(row * int'(IN_WIDTH) + col) * int'(BITWIDTH) +: BITWIDTH];
                  end
`else
                  row = r + i;
                  col = c + j;
                  fm[((int'(FEATURE_MAP_NUM) - 1 - p) * int'(PATCH) + (int'(PATCH) - 1 - e))
                     * int'(BITWIDTH) +: BITWIDTH] =
                     frame[(row * int'(IN_WIDTH) + col) * int'(BITWIDTH) +: BITWIDTH];
`endif
               end
            end
         end
      end
      return fm;
   endfunction

   // Next-state, buffer write and output decode; patches are captured on the edge entering BUILD.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      fm_d    = fm_q;
      accept  = pixel_valid && ready_q;

      case (state_q)
         LOAD: begin
            if (accept) begin
               for (int k = 0; k < int'(NPIX); k++) begin
                  if (cnt_q == CNT_W'(k)) begin
                     frame_d[k * int'(BITWIDTH) +: BITWIDTH] = pixel_in;
                  end
               end
               if (cnt_q == CNT_W'(NPIX - 1)) begin
                  cnt_d   = '0;
                  state_d = BUILD;
                  fm_d    = im2col(frame_d);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         BUILD:   state_d = START;
         START:   state_d = WAIT;
         WAIT: begin
            if (calculate_done) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase

      ready_d = (state_d == LOAD);
      start_d = (state_d == START);
      busy_d  = (state_d != LOAD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         frame_q <= '0;
         fm_q    <= '0;
         ready_q <= 1'b1;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
         fm_q    <= fm_d;
         ready_q <= ready_d;
         start_q <= start_d;
         busy_q  <= busy_d;
      end
   end

   assign pixel_ready     = ready_q;
   assign calculate_start = start_q;
   assign busy            = busy_q;
   assign feature_maps    = fm_q;

endmodule

// File: tb/tb_conv2d_im2col.sv
// Bench for conv2d_im2col: frame-level model of im2col plus handshake timing, with literal patch pins.
module tb_conv2d_im2col;

   localparam int BW    = 8;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int K     = 3;
   localparam int NPIX  = W * H;
`ifdef CONV2D_IM2COL_ZERO_PAD_EN
   localparam int PAD   = 1;
   localparam int OW    = W;
   localparam int OH    = H;
   localparam int E0    = 4;
   localparam int EL    = 4;
`else
   localparam int PAD   = 0;
   localparam int OW    = W - K + 1;
   localparam int OH    = H - K + 1;
   localparam int E0    = 0;
   localparam int EL    = K * K - 1;
`endif
   localparam int FMN   = OW * OH;
   localparam int PATCH = K * K;
   localparam int PW    = PATCH * BW;
   localparam int FM_W  = FMN * PW;
   localparam int LASTP = FMN - 1;

`ifdef CONV2D_IM2COL_ZERO_PAD_EN
   localparam logic [PW-1:0] P0_EXP = 72'h000000_000102_000506;
   localparam logic [PW-1:0] PL_EXP = 72'h0B0C00_0F1000_000000;
`else
   localparam logic [PW-1:0] P0_EXP = 72'h010203_050607_090A0B;
   localparam logic [PW-1:0] PL_EXP = 72'h060708_0A0B0C_0E0F10;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [BW-1:0]   pixel_in;
   logic            pixel_valid;
   logic            pixel_ready;
   logic [FM_W-1:0] feature_maps;
   logic            calculate_start;
   logic            calculate_done;
   logic            busy;

   int checks = 0;
   int errors = 0;

   conv2d_im2col #(
      .BITWIDTH   (BW),
      .IN_WIDTH   (W),
      .IN_HEIGHT  (H),
      .KERNEL_SIZE(K)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pixel_in       (pixel_in),
      .pixel_valid    (pixel_valid),
      .pixel_ready    (pixel_ready),
      .feature_maps   (feature_maps),
      .calculate_start(calculate_start),
      .calculate_done (calculate_done),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] patch_of(input logic [FM_W-1:0] fm, input int p);
      logic [FM_W-1:0] s;
      s = fm >> ((FMN - 1 - p) * PW);
      return s[PW-1:0];
   endfunction

   function automatic logic [BW-1:0] elem_of(input logic [FM_W-1:0] fm, input int p, input int e);
      logic [PW-1:0] q;
      q = patch_of(fm, p) >> ((PATCH - 1 - e) * BW);
      return q[BW-1:0];
   endfunction

   // Model state: frame contents as seen by the handshake, and the expected outputs for the next cycle.
   logic [BW-1:0]   m_pix [NPIX];
   logic [FM_W-1:0] m_fm;
   logic            m_ready;
   logic            m_busy;
   int              m_acc;
   int              cyc = 0;
   int              start_due = -10;
   int              done_from = 1 << 30;
   int              n_starts = 0;
   int              start_cyc = 0;
   int              last_acc_cyc = 0;

   // Builds patches by walking windows in raster order and appending elements MSB-first.
   function automatic logic [FM_W-1:0] model_fm();
      logic [FM_W-1:0] fm;
      logic [BW-1:0]   v;
      int              rr;
      int              cc;
      fm = '0;
      for (int r = 0; r < OH; r++)
         for (int c = 0; c < OW; c++)
            for (int i = 0; i < K; i++)
               for (int j = 0; j < K; j++) begin
                  rr = r + i - PAD;
                  cc = c + j - PAD;
                  if (rr < 0 || rr >= H || cc < 0 || cc >= W) v = '0;
                  else v = m_pix[rr * W + cc];
                  fm = (fm << BW) | FM_W'(v);
               end
      return fm;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         chk("rst_ready", PW'(pixel_ready), PW'(1));
         chk("rst_busy", PW'(busy), PW'(0));
         chk("rst_start", PW'(calculate_start), PW'(0));
         for (int p = 0; p < FMN; p++) chk($sformatf("rst_fm_p%0d", p), patch_of(feature_maps, p), '0);
         m_ready   = 1'b1;
         m_busy    = 1'b0;
         m_acc     = 0;
         m_fm      = '0;
         start_due = -10;
         done_from = 1 << 30;
      end else begin
         chk("ready", PW'(pixel_ready), PW'(m_ready));
         chk("busy", PW'(busy), PW'(m_busy));
         chk("start", PW'(calculate_start), PW'(cyc == start_due));
         for (int p = 0; p < FMN; p++)
            chk($sformatf("fm_p%0d", p), patch_of(feature_maps, p), patch_of(m_fm, p));
         if (calculate_start) begin
            n_starts++;
            start_cyc = cyc;
         end
         if (m_ready && pixel_valid) begin
            m_pix[m_acc] = pixel_in;
            last_acc_cyc = cyc;
            if (m_acc == NPIX - 1) begin
               m_acc     = 0;
               m_ready   = 1'b0;
               m_busy    = 1'b1;
               m_fm      = model_fm();
               start_due = cyc + 2;
               done_from = cyc + 3;
            end else begin
               m_acc++;
            end
         end else if (m_busy && cyc >= done_from && calculate_done) begin
            m_ready = 1'b1;
            m_busy  = 1'b0;
         end
      end
   end

   task automatic send(input logic [BW-1:0] v, input int gap);
      bit ok;
      ok          = 1'b0;
      pixel_in    = v;
      pixel_valid = 1'b1;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (pixel_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=ready_low required=ready_high at %0t", $time);
      end
      @(posedge clk);
      #1;
      if (gap > 0) begin
         pixel_valid = 1'b0;
         pixel_in    = 8'hEE;
         repeat (gap) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input int base, input int gapmax, input bit neg);
      logic [BW-1:0] v;
      for (int k = 0; k < NPIX; k++) begin
         v = BW'(base + k);
         if (neg && k == 0) v = 8'h80;
         if (neg && k == NPIX - 1) v = 8'hFF;
         send(v, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
      end
      pixel_valid = 1'b0;
   endtask

   task automatic wait_start(input int prev);
      int t;
      t = 0;
      while (n_starts <= prev && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (n_starts <= prev) begin
         checks++;
         errors++;
         $display("FAIL start_timeout actual=no_pulse required=pulse at %0t", $time);
      end
   endtask

   task automatic pulse_done(input int delay);
      repeat (delay) @(posedge clk);
      #1;
      calculate_done = 1'b1;
      @(posedge clk);
      #1;
      calculate_done = 1'b0;
   endtask

   initial begin
      int ns;
      rst_n          = 1'b0;
      pixel_in       = '0;
      pixel_valid    = 1'b0;
      calculate_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Frame 1: continuous 1..16, then hold pixel 17 valid through WAIT.
      ns = n_starts;
      send_frame(1, 0, 1'b0);
      pixel_in    = 8'd17;
      pixel_valid = 1'b1;
      wait_start(ns);
      chk("start_latency", PW'(start_cyc - last_acc_cyc), PW'(2));
      chk("f1_patch0", patch_of(feature_maps, 0), P0_EXP);
      chk("f1_patch_last", patch_of(feature_maps, LASTP), PL_EXP);
      pulse_done(5);

      // Frame 2: 17 first, done raised during START must be ignored.
      ns = n_starts;
      send(8'd17, 0);
      for (int k = 18; k <= 32; k++) send(BW'(k), 0);
      pixel_valid = 1'b0;
      @(posedge clk);
      #1;
      calculate_done = 1'b1;
      @(posedge clk);
      #1;
      calculate_done = 1'b0;
      wait_start(ns);
      chk("done_in_start_ignored", PW'(busy), PW'(1));
      chk("f2_first_pixel", PW'(elem_of(feature_maps, 0, E0)), PW'(17));
      pulse_done(3);

      // Frame 3: random valid gaps give the same patches as frame 1.
      ns = n_starts;
      send_frame(1, 3, 1'b0);
      wait_start(ns);
      chk("f3_patch0", patch_of(feature_maps, 0), P0_EXP);
      chk("f3_patch_last", patch_of(feature_maps, LASTP), PL_EXP);
      pulse_done(2);

      // Frame 4: signed extremes copied bit-exact.
      ns = n_starts;
      send_frame(1, 1, 1'b1);
      wait_start(ns);
      chk("neg_first", PW'(elem_of(feature_maps, 0, E0)), PW'(8'h80));
      chk("neg_last", PW'(elem_of(feature_maps, LASTP, EL)), PW'(8'hFF));
      pulse_done(1);

      // Reset after a partial frame, then a clean frame.
      for (int k = 0; k < 7; k++) send(BW'(k + 40), 0);
      pixel_valid = 1'b0;
      rst_n       = 1'b0;
      #1;
      chk("rst_mid_fm_p0", patch_of(feature_maps, 0), '0);
      chk("rst_mid_busy", PW'(busy), PW'(0));
      chk("rst_mid_ready", PW'(pixel_ready), PW'(1));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ns = n_starts;
      send_frame(1, 0, 1'b0);
      wait_start(ns);
      chk("f5_patch0", patch_of(feature_maps, 0), P0_EXP);
      chk("f5_patch_last", patch_of(feature_maps, LASTP), PL_EXP);
      pulse_done(4);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
